// File: rtl/pf_insn_queue.sv
// Instruction queue between the prefetch unit and the decoder: a small circular buffer
// with poison-on-bus-error and flush. Optional same-cycle bypass via macro PFQ_BYPASS_EN.
module pf_insn_queue #(
  parameter int ADDRESS_WIDTH = 30,
  parameter int DATA_WIDTH    = 32,
  parameter int LGFIFO        = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_pf_valid,
  input  logic [DATA_WIDTH-1:0]    i_pf_insn,
  input  logic [ADDRESS_WIDTH-1:0] i_pf_pc,
  input  logic                     i_pf_illegal,
  output logic                     o_pf_stalled_n,
  output logic                     o_valid,
  output logic [DATA_WIDTH-1:0]    o_insn,
  output logic [ADDRESS_WIDTH-1:0] o_pc,
  output logic                     o_illegal,
  input  logic                     i_dcd_stalled_n,
  output logic [LGFIFO:0]          o_fill
);

  localparam int DEPTH = 1 << LGFIFO;
  localparam logic [LGFIFO:0] PTR_MSB = {1'b1, {LGFIFO{1'b0}}};
  localparam logic [LGFIFO:0] PTR_ONE = {{LGFIFO{1'b0}}, 1'b1};
  localparam logic [LGFIFO:0] PTR_ZERO = {(LGFIFO+1){1'b0}};

  logic [DATA_WIDTH-1:0]    insn_mem_r [DEPTH];
  logic [ADDRESS_WIDTH-1:0] pc_mem_r   [DEPTH];
  logic [DEPTH-1:0]         ill_mem_r;

  logic [LGFIFO:0]   wr_ptr_r, rd_ptr_r, fill_r;
  logic [LGFIFO:0]   wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [LGFIFO-1:0] wr_idx_s, rd_idx_s;
  logic              poisoned_r, poisoned_nxt_s;
  logic              full_s, empty_s, push_s, store_s, pop_s, bypass_s;

  assign wr_idx_s = wr_ptr_r[LGFIFO-1:0];
  assign rd_idx_s = rd_ptr_r[LGFIFO-1:0];
  assign full_s   = ((wr_ptr_r ^ rd_ptr_r) == PTR_MSB);
  assign empty_s  = (wr_ptr_r == rd_ptr_r);

  // Acceptance never looks at the decoder side, so there is no combinational path through the queue.
  assign o_pf_stalled_n = i_rst_n && !full_s && !poisoned_r && !i_flush;
  assign push_s         = i_pf_valid && o_pf_stalled_n;

`ifdef PFQ_BYPASS_EN
  assign bypass_s = empty_s && push_s;
`else
  assign bypass_s = 1'b0;
`endif

  // A bypassed word taken by the decoder in the same cycle is never written to storage.
  assign store_s = push_s && !(bypass_s && i_dcd_stalled_n);
  assign pop_s   = !empty_s && i_dcd_stalled_n && !i_flush;
  assign o_fill  = fill_r;

  // Head presentation: the bypass path when active, otherwise the entry at the read pointer.
  always_comb begin
    o_valid   = !empty_s || bypass_s;
    o_insn    = insn_mem_r[rd_idx_s];
    o_pc      = pc_mem_r[rd_idx_s];
    o_illegal = !empty_s && ill_mem_r[rd_idx_s];
    if (bypass_s) begin
      o_insn    = i_pf_insn;
      o_pc      = i_pf_pc;
      o_illegal = i_pf_illegal;
    end else begin
      o_insn    = insn_mem_r[rd_idx_s];
      o_pc      = pc_mem_r[rd_idx_s];
      o_illegal = !empty_s && ill_mem_r[rd_idx_s];
    end
  end

  // Next pointer and poison state; flush drops everything, including this cycle's push and pop.
  always_comb begin
    wr_ptr_nxt_s   = wr_ptr_r;
    rd_ptr_nxt_s   = rd_ptr_r;
    poisoned_nxt_s = poisoned_r;
    if (i_flush) begin
      wr_ptr_nxt_s   = PTR_ZERO;
      rd_ptr_nxt_s   = PTR_ZERO;
      poisoned_nxt_s = 1'b0;
    end else begin
      if (store_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      if (push_s && i_pf_illegal) begin
        poisoned_nxt_s = 1'b1;
      end else begin
        poisoned_nxt_s = poisoned_r;
      end
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      fill_r     <= PTR_ZERO;
      poisoned_r <= 1'b0;
    end else begin
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      fill_r     <= wr_ptr_nxt_s - rd_ptr_nxt_s;
      poisoned_r <= poisoned_nxt_s;
    end
  end

  // Entry storage; contents are qualified by the pointers and need no reset.
  always_ff @(posedge i_clk) begin
    if (store_s) begin
      insn_mem_r[wr_idx_s] <= i_pf_insn;
      pc_mem_r[wr_idx_s]   <= i_pf_pc;
      ill_mem_r[wr_idx_s]  <= i_pf_illegal;
    end
  end

endmodule
